keypad_conditioner: RTL
=======================

KEYPAD_CONDITIONER -- requirements
Module: keypad_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive clock cycles the synchronized enter line SHALL be stable before a press or release is accepted (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 digit_in  input  4  raw keypad digit code, asynchronous to clk.
REQ-005 enter_in  input  1  raw enter pushbutton, asynchronous to clk, bouncy, active-high.
REQ-006 digit_out  output  4  digit captured at the last accepted press; feeds the lock FSM digit input.
REQ-007 enter_pulse  output  1  one-cycle strobe per accepted press; feeds the lock FSM enter input.
REQ-008 key_held  output  1  high while a press is accepted and no release has yet been accepted.
REQ-009 glitch_cnt  output  4  saturating count of rejected (too-short) presses.

Function
REQ-010 digit_in and enter_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The debounce FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when the synchronized enter is 1; the stability counter is cleared to 0.
REQ-013 In PRESS_WAIT, with synchronized enter 1: the counter increments each cycle; when the counter equals DEBOUNCE_CYCLES-1, the next state is PRESSED.
REQ-014 In PRESS_WAIT, with synchronized enter 0: the next state is IDLE and glitch_cnt increments, saturating at 15.
REQ-015 On the PRESS_WAIT->PRESSED transition edge, enter_pulse SHALL register 1 and digit_out SHALL register the synchronized digit on the same edge.
REQ-016 enter_pulse SHALL be high for exactly one cycle per accepted press and is never re-asserted while in PRESSED or RELEASE_WAIT.
REQ-017 Latency: with enter_in held high from the first sampling edge E0, enter_pulse is high in the cycle after edge E0+DEBOUNCE_CYCLES+2.
REQ-018 PRESSED -> RELEASE_WAIT when the synchronized enter is 0; the counter is cleared.
REQ-019 In RELEASE_WAIT, with synchronized enter 0: the counter increments; at DEBOUNCE_CYCLES-1 the next state is IDLE.
REQ-020 In RELEASE_WAIT, with synchronized enter 1: the next state is PRESSED with no pulse and no glitch count.
REQ-021 key_held SHALL be 1 in PRESSED and RELEASE_WAIT and 0 otherwise.
REQ-022 digit_out SHALL hold its value between accepted presses; digit changes while held SHALL be ignored.
REQ-023 The counter SHALL be 8 bits wide and SHALL never wrap, because the terminal compare precedes overflow.

Reset
REQ-024 While rst_n is 0, the following SHALL be forced immediately, independent of clk:
- state = IDLE
- all synchronizer flops = 0
- counter = 0
- digit_out = 0
- enter_pulse = 0
- key_held = 0
- glitch_cnt = 0
REQ-025 Reset asserted mid-press SHALL abort the press with no pulse; after deassertion, a still-held button is processed as a new press from IDLE.

Configuration
REQ-026 Macro KEYPAD_DEBOUNCE_EN: when defined, REQ-012..REQ-020 apply as written.
REQ-027 When KEYPAD_DEBOUNCE_EN is undefined:
- IDLE -> PRESSED occurs directly on synchronized enter 1, with the pulse and digit capture on that edge.
- PRESSED -> IDLE occurs directly on synchronized enter 0.
- PRESS_WAIT and RELEASE_WAIT are unreachable.
- glitch_cnt is tied to 0.
- Latency becomes E0+2.

Structure
REQ-028 Shared package keypad_pkg SHALL hold:
- the four-state enum type
- DEBOUNCE counter width constant (8)
- glitch counter width constant (4)
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by width and instantiated once for 5 bits.

Verification (DEBOUNCE_CYCLES=4, KEYPAD_DEBOUNCE_EN defined unless noted)
REQ-030 Clean press: digit_in=4'h7, enter_in high for 20 cycles -> one enter_pulse 7 cycles after the first sampling edge, digit_out=7, key_held high until 7 cycles after release.
REQ-031 Bounce: enter_in pattern 1,0,1,1,0 then steady 1 -> glitch_cnt=2, exactly one enter_pulse.
REQ-032 Release bounce: while PRESSED, enter_in 0 for 2 cycles then 1 -> state returns to PRESSED, no second pulse, key_held stays 1.
REQ-033 Saturation: 20 presses of 2 cycles each -> glitch_cnt=15 and no enter_pulse.
REQ-034 Reset mid-press: rst_n low during PRESS_WAIT -> all outputs 0 immediately; held button after release of reset -> pulse 7 cycles after the first post-reset edge.
REQ-035 KEYPAD_DEBOUNCE_EN undefined: digit_in=4'h3, single-cycle-wide enter_in -> enter_pulse 2 edges later, digit_out=3, glitch_cnt=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and widths for the keypad conditioner: debounce FSM state
// encoding, stability counter width and glitch counter width.
package keypad_pkg;

  localparam int CNT_W    = 8;
  localparam int GLITCH_W = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for WIDTH independent asynchronous bits; each bit
// is synchronized on its own (no bus coherency is implied).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad front end: synchronizes digit/enter, debounces enter and emits one
// enter strobe plus captured digit per accepted press. Define
// KEYPAD_DEBOUNCE_EN to enable the debounce wait states and glitch counter.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          digit_in,
  input  logic                enter_in,
  output logic [3:0]          digit_out,
  output logic                enter_pulse,
  output logic                key_held,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0] sync_q;
  logic [3:0] digit_s;
  logic       enter_s;

  sync_2ff #(.WIDTH(5)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({digit_in, enter_in}),
    .q     (sync_q)
  );

  assign digit_s = sync_q[4:1];
  assign enter_s = sync_q[0];

  key_state_t state_reg, state_next;
  logic       pulse_next;
  logic [3:0] digit_reg;
  logic       pulse_reg;

`ifdef KEYPAD_DEBOUNCE_EN
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [GLITCH_W-1:0] glitch_reg;
  logic                glitch_inc;

  // Terminal compare happens before the increment, so the counter tops out at TERM.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    glitch_inc = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enter_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!enter_s) begin
          state_next = IDLE;
          glitch_inc = 1'b1;
        end else if (cnt_reg == TERM) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (!enter_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (enter_s) begin
          state_next = PRESSED;
        end else if (cnt_reg == TERM) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      glitch_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (glitch_inc && (glitch_reg != {GLITCH_W{1'b1}})) begin
        glitch_reg <= glitch_reg + 1'b1;
      end
    end
  end

  assign glitch_cnt = glitch_reg;
`else
  // Without debounce the wait states are never entered and TERM is unused.
  logic unused_cfg;
  assign unused_cfg = ^TERM;

  always_comb begin
    state_next = state_reg;
    pulse_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enter_s) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
        end
      end
      PRESSED: begin
        if (!enter_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign glitch_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pulse_reg <= 1'b0;
      digit_reg <= '0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= pulse_next;
      if (pulse_next) begin
        digit_reg <= digit_s;
      end
    end
  end

  assign enter_pulse = pulse_reg;
  assign digit_out   = digit_reg;
  assign key_held    = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

endmodule
